// File: rtl/seq_lz4_header_encoder_pkg.sv
// Shared constants, FSM state type and byte-arithmetic helpers for the
// LZ4 sequence header encoder.
package seq_lz4_header_encoder_pkg;

    localparam int unsigned LZ4_NIBBLE_SAT = 15;
    localparam int unsigned LZ4_EXT_BYTE   = 255;
    localparam int unsigned LZ4_MAX_OFFSET = 65535;

    localparam int unsigned SEQ_LL_BITS_DEF     = 16;
    localparam int unsigned SEQ_ML_BITS_DEF     = 16;
    localparam int unsigned SEQ_OFFSET_BITS_DEF = 17;
    localparam int unsigned MIN_MATCH_LEN_DEF   = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TOKEN,
        S_LL_EXT,
        S_OFF_LO,
        S_OFF_HI,
        S_ML_EXT
    } state_t;

    // Byte emitted for an extension remainder: 0xFF while 255 or more remains.
    function automatic logic [7:0] lz4_ext_byte(input logic [31:0] rem);
        return (rem >= 32'(LZ4_EXT_BYTE)) ? 8'hFF : rem[7:0];
    endfunction

    // The remainder byte (below 255) closes an extension run.
    function automatic logic lz4_ext_last(input logic [31:0] rem);
        return (rem < 32'(LZ4_EXT_BYTE));
    endfunction

    // Token nibble: value saturated at 15.
    function automatic logic [3:0] lz4_nibble(input logic [31:0] v);
        return (v >= 32'(LZ4_NIBBLE_SAT)) ? 4'hF : v[3:0];
    endfunction

endpackage

// File: rtl/seq_lz4_header_encoder_len_ext_counter.sv
// Remainder counter for LZ4 length extensions. Holds the value still to be
// encoded, presents the current extension byte and a look-ahead of the byte
// that follows one step, so the owner can register its output byte.
module lz4_len_ext_counter
    import seq_lz4_header_encoder_pkg::*;
#(
    parameter int unsigned W = SEQ_LL_BITS_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    input  logic         i_step,
    output logic [7:0]   o_byte,
    output logic         o_last,
    output logic [7:0]   o_next_byte,
    output logic         o_next_last
);

    logic [W-1:0] r_rem;
    logic [W-1:0] w_next_rem;

    assign w_next_rem = r_rem - W'(LZ4_EXT_BYTE);

    // Load a fresh remainder, or retire one 0xFF byte per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= '0;
        end else if (i_load) begin
            r_rem <= i_value;
        end else if (i_step) begin
            r_rem <= w_next_rem;
        end
    end

    assign o_byte      = lz4_ext_byte(32'(r_rem));
    assign o_last      = lz4_ext_last(32'(r_rem));
    assign o_next_byte = lz4_ext_byte(32'(w_next_rem));
    assign o_next_last = lz4_ext_last(32'(w_next_rem));

endmodule

// File: rtl/seq_lz4_header_encoder.sv
// LZ4 block header encoder: turns one (ll, ml, offset, delim) sequence into
// token, literal-length extension, little-endian offset and match-length
// extension bytes, one byte per cycle over valid/ready.
module seq_lz4_header_encoder
    import seq_lz4_header_encoder_pkg::*;
#(
    parameter int unsigned SEQ_LL_BITS     = SEQ_LL_BITS_DEF,
    parameter int unsigned SEQ_ML_BITS     = SEQ_ML_BITS_DEF,
    parameter int unsigned SEQ_OFFSET_BITS = SEQ_OFFSET_BITS_DEF,
    parameter int unsigned MIN_MATCH_LEN   = MIN_MATCH_LEN_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_valid,
    input  logic [SEQ_LL_BITS-1:0]     i_ll,
    input  logic [SEQ_ML_BITS-1:0]     i_ml,
    input  logic [SEQ_OFFSET_BITS-1:0] i_offset,
    input  logic                       i_delim,
    output logic                       i_ready,
    output logic                       o_valid,
    output logic [7:0]                 o_data,
    output logic                       o_seq_end,
    output logic                       o_last,
    input  logic                       o_ready,
    output logic                       o_err
);

    state_t                 r_state;
    logic                   r_o_valid;
    logic [7:0]             r_o_data;
    logic                   r_o_seq_end;
    logic                   r_o_last;
    logic                   r_err;
    logic                   r_ll_ext;
    logic                   r_ml_ext;
    logic                   r_delim_form;
    logic                   r_last_en;
    logic [15:0]            r_off;
    logic [SEQ_LL_BITS-1:0] r_mc_rem;

    logic                   w_ml_zero;
    logic                   w_ml_short;
    logic                   w_form_delim;
    logic                   w_illegal;
    logic [SEQ_LL_BITS-1:0] w_ml_ll;
    logic [SEQ_LL_BITS-1:0] w_mc;
    logic                   w_ll_ext;
    logic                   w_mc_ext;
    logic [SEQ_LL_BITS-1:0] w_ll_rem;
    logic [7:0]             w_token;
    logic                   w_token_end;

    logic                   w_cnt_load;
    logic [SEQ_LL_BITS-1:0] w_cnt_value;
    logic                   w_cnt_step;
    logic [7:0]             w_cnt_byte;
    logic                   w_cnt_last;
    logic [7:0]             w_cnt_next_byte;
    logic                   w_cnt_next_last;

    // Latch-time arithmetic on the incoming sequence.
    assign w_ml_zero    = (i_ml == '0);
    assign w_ml_short   = (i_ml < SEQ_ML_BITS'(MIN_MATCH_LEN));
    assign w_form_delim = i_delim | w_ml_zero;
    assign w_illegal    = (!w_ml_zero && w_ml_short)
                        || (w_ml_zero && !i_delim)
                        || (!i_delim && (i_offset == '0))
                        || (i_offset > SEQ_OFFSET_BITS'(LZ4_MAX_OFFSET));
    assign w_ml_ll      = SEQ_LL_BITS'(i_ml);
    assign w_mc         = w_ml_short ? '0 : (w_ml_ll - SEQ_LL_BITS'(MIN_MATCH_LEN));
    assign w_ll_ext     = (i_ll >= SEQ_LL_BITS'(LZ4_NIBBLE_SAT));
    assign w_mc_ext     = (w_mc >= SEQ_LL_BITS'(LZ4_NIBBLE_SAT)) && !w_form_delim;
    assign w_ll_rem     = w_ll_ext ? (i_ll - SEQ_LL_BITS'(LZ4_NIBBLE_SAT)) : '0;
    assign w_token      = {lz4_nibble(32'(i_ll)),
                           w_form_delim ? 4'h0 : lz4_nibble(32'(w_mc))};
    assign w_token_end  = !w_ll_ext && w_form_delim;

    // Shared remainder counter: loaded with ll-15 at accept, mc-15 leaving OFF_HI.
    assign w_cnt_load  = ((r_state == S_IDLE) && i_valid)
                       || ((r_state == S_OFF_HI) && o_ready && r_ml_ext);
    assign w_cnt_value = (r_state == S_IDLE) ? w_ll_rem : r_mc_rem;
    assign w_cnt_step  = o_ready && !w_cnt_last
                       && ((r_state == S_LL_EXT) || (r_state == S_ML_EXT));

    lz4_len_ext_counter #(
        .W (SEQ_LL_BITS)
    ) u_len_ext (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_cnt_load),
        .i_value     (w_cnt_value),
        .i_step      (w_cnt_step),
        .o_byte      (w_cnt_byte),
        .o_last      (w_cnt_last),
        .o_next_byte (w_cnt_next_byte),
        .o_next_last (w_cnt_next_last)
    );

    // Header FSM; each output byte is registered on the transition that selects it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_o_valid    <= 1'b0;
            r_o_data     <= '0;
            r_o_seq_end  <= 1'b0;
            r_o_last     <= 1'b0;
            r_err        <= 1'b0;
            r_ll_ext     <= 1'b0;
            r_ml_ext     <= 1'b0;
            r_delim_form <= 1'b0;
            r_last_en    <= 1'b0;
            r_off        <= '0;
            r_mc_rem     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_ll_ext     <= w_ll_ext;
                        r_ml_ext     <= w_mc_ext;
                        r_delim_form <= w_form_delim;
                        r_last_en    <= i_delim;
                        r_off        <= 16'(i_offset);
                        r_mc_rem     <= w_mc_ext ? (w_mc - SEQ_LL_BITS'(LZ4_NIBBLE_SAT)) : '0;
                        r_err        <= r_err | w_illegal;
                        r_state      <= S_TOKEN;
                        r_o_valid    <= 1'b1;
                        r_o_data     <= w_token;
                        r_o_seq_end  <= w_token_end;
                        r_o_last     <= w_token_end & i_delim;
                    end
                end
                S_TOKEN: begin
                    if (o_ready) begin
                        if (r_ll_ext) begin
                            r_state     <= S_LL_EXT;
                            r_o_data    <= w_cnt_byte;
                            r_o_seq_end <= w_cnt_last & r_delim_form;
                            r_o_last    <= w_cnt_last & r_delim_form & r_last_en;
                        end else if (r_delim_form) begin
                            r_state     <= S_IDLE;
                            r_o_valid   <= 1'b0;
                            r_o_data    <= '0;
                            r_o_seq_end <= 1'b0;
                            r_o_last    <= 1'b0;
                        end else begin
                            r_state     <= S_OFF_LO;
                            r_o_data    <= r_off[7:0];
                            r_o_seq_end <= 1'b0;
                            r_o_last    <= 1'b0;
                        end
                    end
                end
                S_LL_EXT: begin
                    if (o_ready) begin
                        if (!w_cnt_last) begin
                            r_o_data    <= w_cnt_next_byte;
                            r_o_seq_end <= w_cnt_next_last & r_delim_form;
                            r_o_last    <= w_cnt_next_last & r_delim_form & r_last_en;
                        end else if (r_delim_form) begin
                            r_state     <= S_IDLE;
                            r_o_valid   <= 1'b0;
                            r_o_data    <= '0;
                            r_o_seq_end <= 1'b0;
                            r_o_last    <= 1'b0;
                        end else begin
                            r_state     <= S_OFF_LO;
                            r_o_data    <= r_off[7:0];
                            r_o_seq_end <= 1'b0;
                            r_o_last    <= 1'b0;
                        end
                    end
                end
                S_OFF_LO: begin
                    if (o_ready) begin
                        r_state     <= S_OFF_HI;
                        r_o_data    <= r_off[15:8];
                        r_o_seq_end <= !r_ml_ext;
                        r_o_last    <= 1'b0;
                    end
                end
                S_OFF_HI: begin
                    if (o_ready) begin
                        if (r_ml_ext) begin
                            // Counter reloads this same edge; first byte comes straight from r_mc_rem.
                            r_state     <= S_ML_EXT;
                            r_o_data    <= lz4_ext_byte(32'(r_mc_rem));
                            r_o_seq_end <= lz4_ext_last(32'(r_mc_rem));
                            r_o_last    <= 1'b0;
                        end else begin
                            r_state     <= S_IDLE;
                            r_o_valid   <= 1'b0;
                            r_o_data    <= '0;
                            r_o_seq_end <= 1'b0;
                            r_o_last    <= 1'b0;
                        end
                    end
                end
                S_ML_EXT: begin
                    if (o_ready) begin
                        if (!w_cnt_last) begin
                            r_o_data    <= w_cnt_next_byte;
                            r_o_seq_end <= w_cnt_next_last;
                            r_o_last    <= 1'b0;
                        end else begin
                            r_state     <= S_IDLE;
                            r_o_valid   <= 1'b0;
                            r_o_data    <= '0;
                            r_o_seq_end <= 1'b0;
                            r_o_last    <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_o_valid   <= 1'b0;
                    r_o_data    <= '0;
                    r_o_seq_end <= 1'b0;
                    r_o_last    <= 1'b0;
                end
            endcase
        end
    end

    assign i_ready   = (r_state == S_IDLE);
    assign o_valid   = r_o_valid;
    assign o_data    = r_o_data;
    assign o_seq_end = r_o_seq_end;
    assign o_last    = r_o_last;
    assign o_err     = r_err;

endmodule

// File: tb/tb_seq_lz4_header_encoder.sv
// Scoreboard bench for seq_lz4_header_encoder (MIN_MATCH_LEN = 4).
module tb_seq_lz4_header_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic [15:0] i_ll;
    logic [15:0] i_ml;
    logic [16:0] i_offset;
    logic        i_delim;
    logic        i_ready;
    logic        o_valid;
    logic [7:0]  o_data;
    logic        o_seq_end;
    logic        o_last;
    logic        o_ready;
    logic        o_err;

    typedef struct packed {
        logic [7:0] d;
        logic       se;
        logic       last;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   ready_mode = 0;
    bit   exp_err = 1'b0;
    bit   held_v = 1'b0;
    bit   ready_next = 1'b0;
    logic [7:0] held_d;
    logic held_se;
    logic held_last;

    always #5 clk = ~clk;

    seq_lz4_header_encoder #(
        .SEQ_LL_BITS     (16),
        .SEQ_ML_BITS     (16),
        .SEQ_OFFSET_BITS (17),
        .MIN_MATCH_LEN   (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (i_valid),
        .i_ll      (i_ll),
        .i_ml      (i_ml),
        .i_offset  (i_offset),
        .i_delim   (i_delim),
        .i_ready   (i_ready),
        .o_valid   (o_valid),
        .o_data    (o_data),
        .o_seq_end (o_seq_end),
        .o_last    (o_last),
        .o_ready   (o_ready),
        .o_err     (o_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic se, input logic last);
        exp_t e;
        e.d = d;
        e.se = se;
        e.last = last;
        q.push_back(e);
    endtask

    task automatic send(input logic [15:0] ll, input logic [15:0] ml, input logic [16:0] off,
                        input logic delim, input logic [7:0] tok);
        logic was_ready;
        int   n;
        n = 0;
        i_valid  = 1'b1;
        i_ll     = ll;
        i_ml     = ml;
        i_offset = off;
        i_delim  = delim;
        forever begin
            was_ready = i_ready;
            @(posedge clk);
            #1;
            n++;
            if (was_ready || n > 100) break;
        end
        i_valid = 1'b0;
        check("accept", 32'(was_ready), 32'd1);
        check("latency_valid", 32'(o_valid), 32'd1);
        check("latency_token", 32'(o_data), 32'(tok));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain", q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Consumer ready: constant 1, or toggling each cycle.
    initial begin
        o_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) o_ready = ~o_ready;
            else                 o_ready = 1'b1;
        end
    end

    // Monitor: compare every accepted byte against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            held_v     = 1'b0;
            ready_next = 1'b0;
        end else if (o_valid) begin
            check("busy_iready", 32'(i_ready), 32'd0);
            if (held_v) begin
                check("hold_data", 32'(o_data), 32'(held_d));
                check("hold_seq_end", 32'(o_seq_end), 32'(held_se));
                check("hold_last", 32'(o_last), 32'(held_last));
            end
            if (o_ready) begin
                held_v = 1'b0;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", o_data);
                end else begin
                    mon_e = q.pop_front();
                    check("data", 32'(o_data), 32'(mon_e.d));
                    check("seq_end", 32'(o_seq_end), 32'(mon_e.se));
                    check("last", 32'(o_last), 32'(mon_e.last));
                    check("err", 32'(o_err), 32'(exp_err));
                    if (mon_e.se) ready_next = 1'b1;
                end
            end else begin
                held_v    = 1'b1;
                held_d    = o_data;
                held_se   = o_seq_end;
                held_last = o_last;
            end
        end else begin
            if (ready_next) check("bubble_iready", 32'(i_ready), 32'd1);
            ready_next = 1'b0;
            held_v     = 1'b0;
        end
    end

    initial begin
        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_ll     = '0;
        i_ml     = '0;
        i_offset = '0;
        i_delim  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_iready", 32'(i_ready), 32'd1);
        check("rst_ovalid", 32'(o_valid), 32'd0);
        check("rst_odata", 32'(o_data), 32'd0);
        check("rst_seq_end", 32'(o_seq_end), 32'd0);
        check("rst_last", 32'(o_last), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: short literals, short match.
        push(8'h31, 0, 0); push(8'h34, 0, 0); push(8'h12, 1, 0);
        send(16'd3, 16'd5, 17'h1234, 1'b0, 8'h31);
        drain();

        // 2: both extensions with zero remainder.
        push(8'hFF, 0, 0); push(8'h00, 0, 0); push(8'h01, 0, 0); push(8'h00, 0, 0); push(8'h00, 1, 0);
        send(16'd15, 16'd19, 17'd1, 1'b0, 8'hFF);
        drain();

        // 3: delimiters with and without literal extension.
        push(8'hF0, 0, 0); push(8'hFF, 0, 0); push(8'h1E, 1, 1);
        send(16'd300, 16'd0, 17'd0, 1'b1, 8'hF0);
        push(8'h00, 1, 1);
        send(16'd0, 16'd0, 17'd0, 1'b1, 8'h00);
        drain();

        // 4: scenario 2 under a toggling consumer.
        ready_mode = 1;
        push(8'hFF, 0, 0); push(8'h00, 0, 0); push(8'h01, 0, 0); push(8'h00, 0, 0); push(8'h00, 1, 0);
        send(16'd15, 16'd19, 17'd1, 1'b0, 8'hFF);
        drain();
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // 5: illegal short match still encodes; error is sticky.
        exp_err = 1'b1;
        push(8'h00, 0, 0); push(8'h08, 0, 0); push(8'h00, 1, 0);
        send(16'd0, 16'd2, 17'd8, 1'b0, 8'h00);
        drain();
        check("err_set", 32'(o_err), 32'd1);
        push(8'h31, 0, 0); push(8'h34, 0, 0); push(8'h12, 1, 0);
        send(16'd3, 16'd5, 17'h1234, 1'b0, 8'h31);
        drain();
        check("err_sticky", 32'(o_err), 32'd1);

        // 6: asynchronous reset in the middle of a literal extension.
        push(8'hF0, 0, 0); push(8'hFF, 0, 0); push(8'hFF, 0, 0); push(8'h4B, 1, 1);
        send(16'd600, 16'd0, 17'd0, 1'b1, 8'hF0);
        @(posedge clk);
        #1;
        check("mid_ext_valid", 32'(o_valid), 32'd1);
        check("mid_ext_data", 32'(o_data), 32'hFF);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(o_valid), 32'd0);
        q.delete();
        exp_err = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_iready", 32'(i_ready), 32'd1);
        check("post_rst_err", 32'(o_err), 32'd0);
        check("post_rst_valid", 32'(o_valid), 32'd0);
        push(8'h31, 0, 0); push(8'h34, 0, 0); push(8'h12, 1, 0);
        send(16'd3, 16'd5, 17'h1234, 1'b0, 8'h31);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
